// File: rtl/jk_seq_pkg.sv
// Shared types for the JK sequencing controller: FSM state encoding and {J,K} drive modes.
package jk_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam logic [1:0] HOLD   = 2'b00;
  localparam logic [1:0] RESET  = 2'b01;
  localparam logic [1:0] SET    = 2'b10;
  localparam logic [1:0] TOGGLE = 2'b11;

endpackage

// File: rtl/jk_ff_cell.sv
// One edge-triggered JK flip-flop with asynchronous active-low clear.
module jk_ff_cell
  import jk_seq_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic j,
  input  logic k,
  output logic q,
  output logic q_
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q <= 1'b0;
    end else begin
      case ({j, k})
        RESET:   q <= 1'b0;
        SET:     q <= 1'b1;
        TOGGLE:  q <= ~q;
        default: q <= q;
      endcase
    end
  end

  assign q_ = ~q;

endmodule

// File: rtl/jk_seq_ctrl.sv
// Run-to-terminal up/down counter built from a bank of JK cells with a start/busy/done handshake.
// Define JK_SEQ_DOWN_EN to honour the up port; otherwise every run counts up.
module jk_seq_ctrl
  import jk_seq_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             up,
  input  logic             abort,
  input  logic [WIDTH-1:0] init,
  input  logic [WIDTH-1:0] term,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done
);

  state_t           state, next_state;
  logic [WIDTH-1:0] term_q;
  logic             up_q;
  logic [WIDTH-1:0] count_n;
  logic [WIDTH-1:0] j_vec, k_vec;
  logic [WIDTH-1:0] tog;

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      jk_ff_cell u_cell (
        .clk     (clk),
        .reset_n (reset_n),
        .j       (j_vec[i]),
        .k       (k_vec[i]),
        .q       (count[i]),
        .q_      (count_n[i])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      term_q <= '0;
      up_q   <= 1'b0;
    end else begin
      state <= next_state;
      if (state == IDLE && start) begin
        term_q <= term;
`ifdef JK_SEQ_DOWN_EN
        up_q   <= up;
`else
        up_q   <= up | 1'b1;
`endif
      end
    end
  end

  // Ripple toggle enable: a cell toggles when all lower cells are 1 (up) or 0 (down).
  always_comb begin
    logic chain;
    tog   = '0;
    chain = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      tog[i] = chain;
      chain  = chain & (up_q ? count[i] : count_n[i]);
    end
  end

  always_comb begin
    next_state = state;
    j_vec      = '0;
    k_vec      = '0;
    done       = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE: begin
        if (start) begin
          j_vec      = init;
          k_vec      = ~init;
          next_state = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          next_state = IDLE;
        end else if (count == term_q) begin
          next_state = DONE;
        end else begin
          j_vec = tog;
          k_vec = tog;
        end
      end
      DONE: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

endmodule
